// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID register: PC drives async-read imem, instruction lands on IFIDOUT one edge later.
// Backpressure: CNTEN=0 freezes everything, STALL holds PC and IF/ID; redirect beats stall and flushes one bubble.
module if_id_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [63:0]     RESET_PC   = 64'd0,
  parameter logic [63:0]     PC_STEP    = 64'd4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [ILEN-1:0] NOP_INST   = '0
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            CNTEN,
  input  logic            STALL,
  input  logic            PCsel,
  input  logic [XLEN-1:0] JumporBranch,
  output logic [XLEN-1:0] IMEMADDR,
  input  logic [ILEN-1:0] IMEMDATA,
  output logic [XLEN-1:0] IFIDOUTPC,
  output logic [ILEN-1:0] IFIDOUTInst,
  output logic            IFIDOUTValid,
  output logic            MISALIGN
);

  function automatic logic [XLEN-1:0] align_mask();
    logic [XLEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i < ALIGN_BITS) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [XLEN-1:0] ALIGN_MASK = align_mask();
  localparam logic [XLEN-1:0] RESET_PC_T = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] PC_STEP_T  = PC_STEP[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [ILEN-1:0] ifid_inst_q, ifid_inst_d;
  logic            ifid_vld_q, ifid_vld_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    pc_d        = pc_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_vld_d  = ifid_vld_q;
    misalign_d  = misalign_q;
    if (CNTEN) begin
      if (PCsel) begin
        // Redirect: fetch from the aligned target, squash whatever sat in IF/ID.
        pc_d        = JumporBranch & ~ALIGN_MASK;
        ifid_pc_d   = '0;
        ifid_inst_d = NOP_INST;
        ifid_vld_d  = 1'b0;
        misalign_d  = |(JumporBranch & ALIGN_MASK);
      end else if (!STALL) begin
        pc_d        = pc_q + PC_STEP_T;
        ifid_pc_d   = pc_q;
        ifid_inst_d = IMEMDATA;
        ifid_vld_d  = 1'b1;
        misalign_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      pc_q        <= RESET_PC_T;
      ifid_pc_q   <= '0;
      ifid_inst_q <= NOP_INST;
      ifid_vld_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_vld_q  <= ifid_vld_d;
      misalign_q  <= misalign_d;
    end
  end

  assign IMEMADDR     = pc_q;
  assign IFIDOUTPC    = ifid_pc_q;
  assign IFIDOUTInst  = ifid_inst_q;
  assign IFIDOUTValid = ifid_vld_q;
  assign MISALIGN     = misalign_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic against a behavioural model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_rstb = 1'b1, a_en = 1'b0, a_stall = 1'b0, a_sel = 1'b0;
  logic [31:0] a_tgt = '0;
  logic [31:0] a_addr, a_data, a_opc, a_inst;
  logic        a_vld, a_mis;
  assign a_data = a_addr + 32'h1000;

  if_id_stage dut_a (
    .CLK(clk), .RSTB(a_rstb), .CNTEN(a_en), .STALL(a_stall), .PCsel(a_sel),
    .JumporBranch(a_tgt), .IMEMADDR(a_addr), .IMEMDATA(a_data),
    .IFIDOUTPC(a_opc), .IFIDOUTInst(a_inst), .IFIDOUTValid(a_vld), .MISALIGN(a_mis)
  );

  // 8-bit PC instance for wrap/freeze
  logic        b_rstb = 1'b1, b_en = 1'b0, b_stall = 1'b0, b_sel = 1'b0;
  logic [7:0]  b_tgt = '0;
  logic [7:0]  b_addr, b_opc;
  logic [31:0] b_data, b_inst;
  logic        b_vld, b_mis;
  assign b_data = {24'h0, b_addr} + 32'h1000;

  if_id_stage #(.XLEN(8), .RESET_PC(64'hF8)) dut_b (
    .CLK(clk), .RSTB(b_rstb), .CNTEN(b_en), .STALL(b_stall), .PCsel(b_sel),
    .JumporBranch(b_tgt), .IMEMADDR(b_addr), .IMEMDATA(b_data),
    .IFIDOUTPC(b_opc), .IFIDOUTInst(b_inst), .IFIDOUTValid(b_vld), .MISALIGN(b_mis)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Behavioural model of dut_a: what the pipeline must hold after each edge.
  logic [31:0] m_pc, m_opc, m_inst;
  logic        m_vld, m_mis;
  bit          chk_en = 1'b0;

  // Apply one edge to dut_a; called at posedge+1 so inputs and model move together.
  task automatic step(input logic rstb, input logic en, input logic st,
                      input logic sel, input logic [31:0] tgt);
    logic [31:0] n_pc, n_opc, n_inst;
    logic        n_vld, n_mis;
    a_rstb = rstb; a_en = en; a_stall = st; a_sel = sel; a_tgt = tgt;
    n_pc = m_pc; n_opc = m_opc; n_inst = m_inst; n_vld = m_vld; n_mis = m_mis;
    if (!rstb) begin
      n_pc = 0; n_opc = 0; n_inst = 0; n_vld = 0; n_mis = 0;
    end else if (en && sel) begin
      n_pc  = {tgt[31:2], 2'b00};
      n_opc = 0; n_inst = 0; n_vld = 0;
      n_mis = (tgt % 4) != 0;
    end else if (en && !st) begin
      n_opc  = m_pc;
      n_inst = m_pc + 32'h1000;
      n_vld  = 1;
      n_pc   = m_pc + 4;
      n_mis  = 0;
    end
    @(posedge clk); #1;
    m_pc = n_pc; m_opc = n_opc; m_inst = n_inst; m_vld = n_vld; m_mis = n_mis;
    chk_en = 1'b1;
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imemaddr", a_addr, m_pc);
      chk("m_ifidpc",   a_opc,  m_opc);
      chk("m_inst",     a_inst, m_inst);
      chk("m_valid",    32'(a_vld), 32'(m_vld));
      chk("m_misalign", 32'(a_mis), 32'(m_mis));
    end
  end

  task automatic step_b(input logic rstb, input logic en, input logic sel, input logic [7:0] tgt);
    b_rstb = rstb; b_en = en; b_stall = 1'b0; b_sel = sel; b_tgt = tgt;
    @(posedge clk); #1;
  endtask

  initial begin
    m_pc = 0; m_opc = 0; m_inst = 0; m_vld = 0; m_mis = 0;
    #1;
    // 1: reset and run
    step(0, 1, 0, 0, 0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_valid", 32'(a_vld), 32'h0);
    chk("rst_inst", a_inst, 32'h0);
    step(1, 1, 0, 0, 0);
    chk("adv1_pc", a_opc, 32'h0);
    chk("adv1_inst", a_inst, 32'h1000);
    chk("adv1_valid", 32'(a_vld), 32'h1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("adv3_pc", a_opc, 32'h8);
    chk("adv3_inst", a_inst, 32'h1008);
    chk("adv3_addr", a_addr, 32'hC);
    // 2: stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0);
      chk("stall_pc", a_opc, 32'h8);
      chk("stall_addr", a_addr, 32'hC);
    end
    step(1, 1, 0, 0, 0);
    chk("rel_pc", a_opc, 32'hC);
    chk("rel_inst", a_inst, 32'h100C);
    // 3: redirect wins over stall
    step(1, 1, 1, 1, 32'h40);
    chk("redir_addr", a_addr, 32'h40);
    chk("redir_valid", 32'(a_vld), 32'h0);
    chk("redir_inst", a_inst, 32'h0);
    step(1, 1, 0, 0, 0);
    chk("tgt_pc", a_opc, 32'h40);
    chk("tgt_inst", a_inst, 32'h1040);
    // 4: misaligned target, held by stall, cleared by advance
    step(1, 1, 0, 1, 32'h43);
    chk("mis_addr", a_addr, 32'h40);
    chk("mis_flag", 32'(a_mis), 32'h1);
    step(1, 1, 1, 0, 0);
    chk("mis_hold", 32'(a_mis), 32'h1);
    step(1, 1, 0, 0, 0);
    chk("mis_clr", 32'(a_mis), 32'h0);
    chk("mis_pc", a_opc, 32'h40);
    // freeze: CNTEN=0 ignores redirect
    step(1, 0, 0, 1, 32'h80);
    chk("frz_addr", a_addr, 32'h44);
    chk("frz_pc", a_opc, 32'h40);
    chk("frz_valid", 32'(a_vld), 32'h1);
    // 6: mid-run reset at PC=0x20
    step(1, 1, 0, 1, 32'h1C);
    step(1, 1, 0, 0, 0);
    chk("pre_rst_addr", a_addr, 32'h20);
    chk("pre_rst_valid", 32'(a_vld), 32'h1);
    step(0, 1, 0, 0, 0);
    chk("mrst_addr", a_addr, 32'h0);
    chk("mrst_pc", a_opc, 32'h0);
    chk("mrst_valid", 32'(a_vld), 32'h0);
    chk("mrst_inst", a_inst, 32'h0);
    step(1, 1, 0, 0, 0);
    chk("resume_inst", a_inst, 32'h1000);
    chk("resume_addr", a_addr, 32'h4);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) != 0, $urandom_range(9) != 0, $urandom_range(3) == 0,
           $urandom_range(9) == 0, $urandom);
    end
    // 5: 8-bit wrap and freeze (dut_a parked frozen)
    step(1, 0, 0, 0, 0);
    step_b(0, 1, 0, 0);
    chk("b_rst_addr", 32'(b_addr), 32'hF8);
    step_b(1, 1, 0, 0);
    chk("b_adv1_pc", 32'(b_opc), 32'hF8);
    step_b(1, 1, 0, 0);
    chk("b_adv2_pc", 32'(b_opc), 32'hFC);
    chk("b_wrap_addr", 32'(b_addr), 32'h00);
    step_b(1, 1, 0, 0);
    chk("b_adv3_pc", 32'(b_opc), 32'h00);
    chk("b_adv3_inst", b_inst, 32'h1000);
    step_b(1, 0, 1, 8'h80);
    chk("b_frz_addr", 32'(b_addr), 32'h04);
    chk("b_frz_pc", 32'(b_opc), 32'h00);
    chk("b_frz_valid", 32'(b_vld), 32'h1);
    chk("b_frz_inst", b_inst, 32'h1000);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised instruction-fetch stage plus IF/ID pipeline register.
- Generates the program counter and drives an external asynchronous-read instruction memory.
- Latches PC/instruction pairs for decode.
- Over the single-cycle fetch block it adds stall, redirect-flush, a valid bit, configurable width/step/reset vector, and misaligned-target detection.

Parameters:
- XLEN, 32, width of PC and redirect target.
- ILEN, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.
- ALIGN_BITS, 2, number of target LSBs that must be zero; 0 disables alignment checking.
- NOP_INST, 0, instruction word inserted on flush/reset.

Ports:
- CLK  in  1  rising-edge clock.
- RSTB  in  1  synchronous active-low reset.
- CNTEN  in  1  global advance enable; 0 freezes all state.
- STALL  in  1  hazard stall; holds PC and IF/ID register.
- PCsel  in  1  redirect request; 1 selects JumporBranch.
- JumporBranch  in  XLEN  redirect target address.
- IMEMADDR  out  XLEN  instruction memory address (= current PC, combinational).
- IMEMDATA  in  ILEN  instruction memory read data, valid in the same cycle as IMEMADDR.
- IFIDOUTPC  out  XLEN  PC of the latched instruction.
- IFIDOUTInst  out  ILEN  latched instruction.
- IFIDOUTValid  out  1  1 = IFIDOUTInst is a real instruction.
- MISALIGN  out  1  registered flag: the last accepted redirect target was misaligned.

Behaviour:
- Single clock; all state updates on the rising CLK edge.
- Reset is synchronous: RSTB=0 at an edge overrides every other input. Reset values:
  - PC=RESET_PC
  - IFIDOUTPC=0
  - IFIDOUTInst=NOP_INST
  - IFIDOUTValid=0
  - MISALIGN=0
- RSTB asserted mid-stream discards any in-flight instruction immediately at that edge.
- IMEMADDR = PC at all times, including while frozen.
- Priority at each edge with RSTB=1:
  - CNTEN=0: hold everything; PCsel and STALL are ignored.
  - CNTEN=1, PCsel=1 (redirect, wins over STALL):
    - PC <= JumporBranch with the low ALIGN_BITS forced to 0.
    - IF/ID flushed: Inst=NOP_INST, Valid=0, IFIDOUTPC=0.
    - MISALIGN <= OR of the original low ALIGN_BITS of JumporBranch.
  - CNTEN=1, PCsel=0, STALL=1:
    - PC and IF/ID hold.
    - MISALIGN holds.
  - CNTEN=1, PCsel=0, STALL=0 (normal advance):
    - IFIDOUTPC <= PC, IFIDOUTInst <= IMEMDATA, Valid <= 1.
    - PC <= PC + PC_STEP, modulo 2^XLEN (wraps silently; no flag).
    - MISALIGN <= 0.
- Latency:
  - An instruction at address A appears on IFIDOUT one edge after PC=A with an advance.
  - After a redirect edge: one bubble (Valid=0) cycle, then the target instruction on the following advance edge.
- With ALIGN_BITS=0, MISALIGN is constant 0 and targets are used unmodified.
- STALL held indefinitely keeps outputs stable; no instruction is lost or duplicated on release.
- PC_STEP and RESET_PC are truncated to XLEN bits.

Test Plan:
1. Reset and run (defaults), RSTB=0 for 1 edge, then CNTEN=1, memory returns addr+32'h1000:
   - After the 1st advance edge: IFIDOUTPC=0, Inst=32'h1000, Valid=1.
   - After the 3rd: PC=8, Inst=32'h1008.
2. Stall: at PC=12, assert STALL for 3 cycles:
   - IFIDOUTPC stays 8, IMEMADDR stays 12.
   - On release: next edge gives IFIDOUTPC=12, Inst=32'h100C.
3. Redirect during stall: STALL=1, PCsel=1, JumporBranch=32'h40:
   - Next edge: PC=32'h40, Valid=0, Inst=0.
   - Following advance edge: IFIDOUTPC=32'h40, Inst=32'h1040.
4. Misaligned target: PCsel=1, JumporBranch=32'h43:
   - PC=32'h40, MISALIGN=1.
   - MISALIGN returns to 0 on the next advance.
5. Wrap and freeze, XLEN=8, RESET_PC=8'hF8:
   - Advances give PCs F8, FC, 00.
   - CNTEN=0 with PCsel=1 leaves PC and outputs unchanged.
6. Mid-run reset: at PC=32'h20, Valid=1, pull RSTB low for one edge:
   - All outputs at reset values.
   - IMEMADDR=RESET_PC.
   - Fetch resumes from RESET_PC.
